// File: rtl/ring_tx_link.sv
// ring_tx_link
// Ring-side transmitter for one outgoing ring link. Flits from the local core
// are queued and presented one at a time to the downstream router using a
// valid/ready handshake. Data is held stable while the router back-pressures.
// Null flits (type 3'b000) are accepted and then discarded. Flush removes every
// queued flit except the one already on the link.
//
// Optional feature: define RING_TX_WDOG_EN to enable the stall watchdog that
// drives Link_Err. Without it Link_Err is tied low.
//
// Ports:
//   Clk_R          clock, rising edge
//   Rst_n          asynchronous active-low reset
//   Flit_In        55-bit flit: [54:52] type, [51:48] dest, [47:0] payload
//   Flit_In_Valid  Flit_In is valid
//   Flit_In_Ready  the queue can accept a flit this cycle
//   Flush          1-cycle pulse that discards queued flits not yet presented
//   TX_Data        flit presented to the downstream router
//   TX_Data_Valid  TX_Data is valid
//   TX_Data_Ready  the downstream router accepts TX_Data
//   Fifo_Count     occupancy, including the output stage
//   Flit_Sent      1-cycle pulse after each completed TX handshake
//   Link_Err       sticky stall error (watchdog build only)

module ring_tx_link #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                       Clk_R,
    input  logic                       Rst_n,
    input  logic [54:0]                Flit_In,
    input  logic                       Flit_In_Valid,
    output logic                       Flit_In_Ready,
    input  logic                       Flush,
    output logic [54:0]                TX_Data,
    output logic                       TX_Data_Valid,
    input  logic                       TX_Data_Ready,
    output logic [$clog2(DEPTH+1)-1:0] Fifo_Count,
    output logic                       Flit_Sent,
    output logic                       Link_Err
);

    localparam int FIFO_D = DEPTH - 1;
    localparam int PTR_W  = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    if (DEPTH < 2 || TIMEOUT < 1) begin : g_param_check
        $error("ring_tx_link: DEPTH must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_t;

    state_t             state, state_next;
    logic [54:0]        mem [FIFO_D];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [54:0]        tx_data;
    logic               flit_sent;

    logic tx_valid, hs, push_ok;
    logic load_out, load_from_fifo, fifo_wr, fifo_rd, fifo_clr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(FIFO_D - 1)) ? '0 : p + 1'b1;
    endfunction

    // Valid comes straight from the state register, so it never depends on Ready.
    assign tx_valid      = (state != IDLE);
    assign hs            = tx_valid & TX_Data_Ready;
    assign Fifo_Count    = fifo_cnt + {{(CNT_W-1){1'b0}}, tx_valid};
    assign Flit_In_Ready = (Fifo_Count != CNT_W'(DEPTH)) && (state != FLUSH);

    // A flush drops any same-cycle push; null flits are swallowed here.
    assign push_ok = Flit_In_Valid & Flit_In_Ready & (Flit_In[54:52] != 3'b000) & ~Flush;

    assign TX_Data       = tx_data;
    assign TX_Data_Valid = tx_valid;
    assign Flit_Sent     = flit_sent;

    always_ff @(posedge Clk_R or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Output-stage control. The output register is refilled from the FIFO head
    // when one is waiting; a push into an otherwise empty block bypasses the
    // FIFO and lands in the output register directly.
    always_comb begin
        state_next     = state;
        load_out       = 1'b0;
        load_from_fifo = 1'b0;
        fifo_wr        = 1'b0;
        fifo_rd        = 1'b0;
        fifo_clr       = 1'b0;
        case (state)
            IDLE: begin
                if (Flush) begin
                    fifo_clr = 1'b1;
                end else if (push_ok) begin
                    load_out   = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (Flush) begin
                    fifo_clr   = 1'b1;
                    state_next = hs ? IDLE : FLUSH;
                end else if (hs) begin
                    if (fifo_cnt != '0) begin
                        load_out       = 1'b1;
                        load_from_fifo = 1'b1;
                        fifo_rd        = 1'b1;
                        fifo_wr        = push_ok;
                    end else if (push_ok) begin
                        load_out = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    fifo_wr = push_ok;
                end
            end
            FLUSH: begin
                if (hs) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output register, FIFO pointers/occupancy and the sent pulse.
    always_ff @(posedge Clk_R or negedge Rst_n) begin
        if (!Rst_n) begin
            tx_data   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            flit_sent <= 1'b0;
        end else begin
            flit_sent <= hs;
            if (load_out) tx_data <= load_from_fifo ? mem[rd_ptr] : Flit_In;
            if (fifo_clr) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
            end else begin
                if (fifo_wr) wr_ptr <= ptr_inc(wr_ptr);
                if (fifo_rd) rd_ptr <= ptr_inc(rd_ptr);
                case ({fifo_wr, fifo_rd})
                    2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                    2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                    default: fifo_cnt <= fifo_cnt;
                endcase
            end
        end
    end

    // FIFO storage needs no reset; occupancy tracking guards every read.
    always_ff @(posedge Clk_R) begin
        if (fifo_wr) mem[wr_ptr] <= Flit_In;
    end

`ifdef RING_TX_WDOG_EN
    localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [WD_W-1:0] stall_cnt;
    logic            link_err;

    // Counts consecutive back-pressured cycles; saturates at TIMEOUT and
    // latches the error on the edge where the count reaches it.
    always_ff @(posedge Clk_R or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cnt <= '0;
            link_err  <= 1'b0;
        end else if (!tx_valid || TX_Data_Ready) begin
            stall_cnt <= '0;
        end else if (stall_cnt != WD_W'(TIMEOUT)) begin
            stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt + 1'b1 == WD_W'(TIMEOUT)) link_err <= 1'b1;
        end
    end

    assign Link_Err = link_err;
`else
    assign Link_Err = 1'b0;
`endif

endmodule

// File: tb/tb_ring_tx_link.sv
// tb_ring_tx_link
// Randomised and directed stimulus for ring_tx_link. The reference model is a
// plain queue of the flits the block holds (front = flit on the link). The
// driver updates the queue for pushes and flushes; a separate monitor pops the
// front on every observed handshake and compares the data sent.

module tb_ring_tx_link;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 255;
    localparam int CW      = $clog2(DEPTH + 1);

    logic          Clk_R = 1'b0;
    logic          Rst_n = 1'b0;
    logic [54:0]   Flit_In = '0;
    logic          Flit_In_Valid = 1'b0;
    logic          Flit_In_Ready;
    logic          Flush = 1'b0;
    logic [54:0]   TX_Data;
    logic          TX_Data_Valid;
    logic          TX_Data_Ready = 1'b0;
    logic [CW-1:0] Fifo_Count;
    logic          Flit_Sent;
    logic          Link_Err;

    ring_tx_link #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .Clk_R         (Clk_R),
        .Rst_n         (Rst_n),
        .Flit_In       (Flit_In),
        .Flit_In_Valid (Flit_In_Valid),
        .Flit_In_Ready (Flit_In_Ready),
        .Flush         (Flush),
        .TX_Data       (TX_Data),
        .TX_Data_Valid (TX_Data_Valid),
        .TX_Data_Ready (TX_Data_Ready),
        .Fifo_Count    (Fifo_Count),
        .Flit_Sent     (Flit_Sent),
        .Link_Err      (Link_Err)
    );

    always #5 Clk_R = ~Clk_R;

    int          checks = 0;
    int          passes = 0;
    logic [54:0] model_q [$];
    bit          flush_mode = 1'b0;
    bit          hs_prev = 1'b0;
`ifdef RING_TX_WDOG_EN
    int          stall_run = 0;
    bit          err_model = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [54:0] rand_flit(input bit allow_null);
        logic [54:0] f;
        f = {$urandom, $urandom};
        if (!allow_null && f[54:52] == 3'b000) f[54:52] = 3'b101;
        return f;
    endfunction

    // Compares the visible block state against the reference queue.
    task automatic checkOutput();
        check("tx_valid",   64'(TX_Data_Valid), 64'(model_q.size() > 0));
        check("fifo_count", 64'(Fifo_Count),    64'(model_q.size()));
        check("in_ready",   64'(Flit_In_Ready), 64'((model_q.size() != DEPTH) && !flush_mode));
        if (model_q.size() > 0) check("tx_data", 64'(TX_Data), 64'(model_q[0]));
`ifdef RING_TX_WDOG_EN
        check("link_err", 64'(Link_Err), 64'(err_model));
`else
        check("link_err", 64'(Link_Err), 64'd0);
`endif
    endtask

    // Drives one cycle of inputs, applies its effect to the model, then checks.
    task automatic applyStimulus(input bit v, input logic [54:0] f, input bit fl, input bit r);
        bit acc;
        Flit_In_Valid = v;
        Flit_In       = f;
        Flush         = fl;
        TX_Data_Ready = r;
        acc = v && (model_q.size() != DEPTH) && !flush_mode;
`ifdef RING_TX_WDOG_EN
        if (model_q.size() > 0 && !r) begin
            stall_run++;
            if (stall_run >= TIMEOUT) err_model = 1'b1;
        end else begin
            stall_run = 0;
        end
`endif
        if (fl) begin
            while (model_q.size() > 1) void'(model_q.pop_back());
            if (model_q.size() > 0 && !r) flush_mode = 1'b1;
        end else if (acc && f[54:52] != 3'b000) begin
            model_q.push_back(f);
        end
        @(posedge Clk_R);
        #1;
        if (model_q.size() == 0) flush_mode = 1'b0;
        checkOutput();
    endtask

    // Monitor: on each handshake pop the expected flit and compare.
    always @(negedge Clk_R) begin
        if (Rst_n) begin
            check("flit_sent", 64'(Flit_Sent), 64'(hs_prev));
            hs_prev = TX_Data_Valid && TX_Data_Ready;
            if (hs_prev) begin
                if (model_q.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_send: got %0h expected no handshake", TX_Data);
                end else begin
                    check("sent_data", 64'(TX_Data), 64'(model_q.pop_front()));
                end
            end
        end else begin
            hs_prev = 1'b0;
        end
    end

    initial begin
        logic [54:0] f1;
        f1 = {3'b001, 4'h1, 48'h2345_6789_ABCD};

        #1;
        check("rst_tx_data",   64'(TX_Data),       64'd0);
        check("rst_tx_valid",  64'(TX_Data_Valid), 64'd0);
        check("rst_count",     64'(Fifo_Count),    64'd0);
        check("rst_flit_sent", 64'(Flit_Sent),     64'd0);
        check("rst_link_err",  64'(Link_Err),      64'd0);
        repeat (2) @(posedge Clk_R);
        @(negedge Clk_R);
        Rst_n = 1'b1;

        // Single flit with the router ready.
        applyStimulus(1'b1, f1, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Fill under back-pressure; the fifth push must be refused.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, rand_flit(1'b0), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Long stall holding one flit, then random ready.
        applyStimulus(1'b1, rand_flit(1'b0), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++)
            applyStimulus(1'($urandom_range(0, 1)), rand_flit(1'b0), 1'b0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Flush with three queued: only the presented flit survives.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, rand_flit(1'b0), 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b1, rand_flit(1'b0), 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Null flit is swallowed; the next normal flit goes out.
        applyStimulus(1'b1, {3'b000, 52'hF_FFFF_FFFF_FFFF}, 1'b0, 1'b1);
        applyStimulus(1'b1, {3'b010, 4'h7, 48'hDEAD_BEEF_0001}, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Randomised traffic, including null flits and occasional flushes.
        for (int i = 0; i < 600; i++)
            applyStimulus(($urandom % 4) != 0, rand_flit(1'b1), ($urandom % 25) == 0, ($urandom % 3) != 0);
        for (int i = 0; i < 2 * DEPTH; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);

`ifdef RING_TX_WDOG_EN
        applyStimulus(1'b1, rand_flit(1'b0), 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT + 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, rand_flit(1'b0), 1'b0, 1'b1);
        for (int i = 0; i < 2 * DEPTH; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
`endif

        // Reset while flits are in flight clears everything at once.
        applyStimulus(1'b1, rand_flit(1'b0), 1'b0, 1'b0);
        applyStimulus(1'b1, rand_flit(1'b0), 1'b0, 1'b0);
        Rst_n = 1'b0;
        #1;
        model_q.delete();
        flush_mode = 1'b0;
`ifdef RING_TX_WDOG_EN
        stall_run = 0;
        err_model = 1'b0;
`endif
        checkOutput();
        @(negedge Clk_R);
        Rst_n = 1'b1;
        applyStimulus(1'b1, rand_flit(1'b0), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
